// File: rtl/add_job_arbiter.sv
// add_job_arbiter: two-requester round-robin front end that runs each operand pair
// through an Avalon-MM adder slave (write A, write B, read sum) and returns the result.
module add_job_arbiter #(
   parameter int         DATA_W   = 32,
   parameter logic [2:0] ADDR_A   = 3'b000,
   parameter logic [2:0] ADDR_B   = 3'b001,
   parameter logic [2:0] ADDR_SUM = 3'b011
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              req1_ready,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [2:0]        av_address,
   output logic              av_write,
   output logic              av_read,
   output logic [DATA_W-1:0] av_writedata,
   input  logic [DATA_W-1:0] av_readdata,
   output logic              busy
);
   typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD, CAP, RSP} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
   logic              gnt_q, gnt_d, ptr_q, ptr_d, win, accept;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         rsp_data_q <= '0;
         gnt_q      <= 1'b0;
         ptr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rsp_data_q <= rsp_data_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
      end
   end
   // ready is combinational, so it is gated by reset to keep every output low during reset
   always_comb begin
      win          = (req0_valid && req1_valid) ? ptr_q : req1_valid;
      accept       = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
      req0_ready   = accept && !win;
      req1_ready   = accept && win;
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_data_d   = rsp_data_q;
      gnt_d        = gnt_q;
      ptr_d        = ptr_q;
      av_address   = 3'b000;
      av_write     = 1'b0;
      av_read      = 1'b0;
      av_writedata = '0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            state_d = WR_A;
            a_d     = win ? req1_a : req0_a;
            b_d     = win ? req1_b : req0_b;
            gnt_d   = win;
         end
         WR_A: begin
            av_write     = 1'b1;
            av_address   = ADDR_A;
            av_writedata = a_q;
            state_d      = WR_B;
         end
         WR_B: begin
            av_write     = 1'b1;
            av_address   = ADDR_B;
            av_writedata = b_q;
            state_d      = RD;
         end
         RD: begin
            av_read    = 1'b1;
            av_address = ADDR_SUM;
            state_d    = CAP;
         end
         CAP: begin
            rsp_data_d = av_readdata;
            state_d    = RSP;
         end
         RSP: begin
            rsp0_valid = !gnt_q;
            rsp1_valid = gnt_q;
            if (gnt_q ? rsp1_ready : rsp0_ready) begin
               state_d = IDLE;
               ptr_d   = !gnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign rsp_data = rsp_data_q;
   assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_add_job_arbiter.sv
// tb_add_job_arbiter: directed scenarios against a registered adder slave model.
module tb_add_job_arbiter;
   logic        clock, reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_data, av_writedata, av_readdata;
   logic [2:0]  av_address;
   logic        av_write, av_read, busy;
   logic [31:0] slv_a, slv_b;
   int          total, passed;

   add_job_arbiter dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .av_address(av_address), .av_write(av_write), .av_read(av_read),
      .av_writedata(av_writedata), .av_readdata(av_readdata), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // registered adder slave, readdata valid the cycle after av_read
   always @(posedge clock) begin
      if (av_write && av_address == 3'd0) slv_a <= av_writedata;
      if (av_write && av_address == 3'd1) slv_b <= av_writedata;
      if (av_read && av_address == 3'd3) av_readdata <= slv_a + slv_b;
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (av_write && av_read) begin
            total++;
            $display("FAIL assert_strobes: av_write and av_read both high");
         end
         if (rsp0_valid && rsp1_valid) begin
            total++;
            $display("FAIL assert_rsp: rsp0_valid and rsp1_valid both high");
         end
         if ((req0_ready || req1_ready) && busy) begin
            total++;
            $display("FAIL assert_ready: reqN_ready high outside IDLE");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic start_job(input bit id, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      #1;
      total++;
      if ((id ? req1_ready : req0_ready) !== 1'b1) $display("FAIL accept%0d: ready=%b want 1", id, id ? req1_ready : req0_ready);
      else passed++;
      @(negedge clock);
      if (id) begin req1_valid = 1'b0; req1_a = 32'hDEAD; req1_b = 32'hBEEF; end
      else begin req0_valid = 1'b0; req0_a = 32'hDEAD; req0_b = 32'hBEEF; end
   endtask

   task automatic finish_job(input bit id, input logic [31:0] exp);
      repeat (4) @(negedge clock);
      total++;
      if ({rsp1_valid, rsp0_valid, rsp_data} !== {id, !id, exp})
         $display("FAIL rsp%0d: valid1/0=%b%b data=%h want %b%b %h", id, rsp1_valid, rsp0_valid, rsp_data, id, !id, exp);
      else passed++;
      @(negedge clock);
      total++;
      if (busy !== 1'b0) $display("FAIL idle_after_rsp%0d: busy=%b want 0", id, busy);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      repeat (2) @(negedge clock);
      total++;
      if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, av_write, av_read, av_address, av_writedata, rsp_data} !== '0)
         $display("FAIL reset_outputs: busy=%b rdy=%b%b rspv=%b%b wr=%b rd=%b addr=%h wd=%h data=%h want all 0",
                  busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, av_write, av_read, av_address, av_writedata, rsp_data);
      else passed++;
      req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
   endtask

   task automatic test_single();
      rsp0_ready = 1'b1;
      start_job(1'b0, 32'd5, 32'd7);
      total++;
      if ({av_write, av_read, av_address, av_writedata} !== {1'b1, 1'b0, 3'd0, 32'd5})
         $display("FAIL wr_a: wr=%b rd=%b addr=%0d wd=%0d want 1 0 0 5", av_write, av_read, av_address, av_writedata);
      else passed++;
      @(negedge clock);
      total++;
      if ({av_write, av_read, av_address, av_writedata} !== {1'b1, 1'b0, 3'd1, 32'd7})
         $display("FAIL wr_b: wr=%b rd=%b addr=%0d wd=%0d want 1 0 1 7", av_write, av_read, av_address, av_writedata);
      else passed++;
      @(negedge clock);
      total++;
      if ({av_write, av_read, av_address, av_writedata} !== {1'b0, 1'b1, 3'd3, 32'd0})
         $display("FAIL rd: wr=%b rd=%b addr=%0d wd=%0d want 0 1 3 0", av_write, av_read, av_address, av_writedata);
      else passed++;
      @(negedge clock);
      total++;
      if ({rsp0_valid, busy, av_write, av_read, av_address, av_writedata} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0})
         $display("FAIL cap: rsp0_valid=%b busy=%b wr=%b rd=%b addr=%0d wd=%0d want 0 1 0 0 0 0",
                  rsp0_valid, busy, av_write, av_read, av_address, av_writedata);
      else passed++;
      @(negedge clock);
      total++;
      if ({rsp0_valid, rsp1_valid, rsp_data} !== {1'b1, 1'b0, 32'd12})
         $display("FAIL rsp_single: valid0/1=%b%b data=%0d want 1 0 12", rsp0_valid, rsp1_valid, rsp_data);
      else passed++;
      @(negedge clock);
      total++;
      if (busy !== 1'b0) $display("FAIL single_idle: busy=%b want 0", busy);
      else passed++;
   endtask

   task automatic test_contention();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;
      req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL contend_first: rdy0/1=%b%b want 10", req0_ready, req1_ready);
      else passed++;
      @(negedge clock);
      req0_valid = 1'b0;
      finish_job(1'b0, 32'd3);
      req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd100;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL contend_second: rdy0/1=%b%b want 01", req0_ready, req1_ready);
      else passed++;
      @(negedge clock);
      req1_valid = 1'b0;
      total++;
      if (av_writedata !== 32'd10) $display("FAIL contend_opa: wd=%0d want 10", av_writedata);
      else passed++;
      finish_job(1'b1, 32'd30);
      req0_valid = 1'b0;
   endtask

   task automatic test_wrap();
      start_job(1'b0, 32'hFFFF_FFFF, 32'd2);
      finish_job(1'b0, 32'd1);
   endtask

   task automatic test_backpressure();
      rsp1_ready = 1'b0;
      start_job(1'b1, 32'd7, 32'd8);
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
      repeat (4) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({rsp1_valid, rsp0_valid, busy, req0_ready, rsp_data} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd15})
            $display("FAIL hold%0d: v1=%b v0=%b busy=%b rdy0=%b data=%0d want 1 0 1 0 15",
                     i, rsp1_valid, rsp0_valid, busy, req0_ready, rsp_data);
         else passed++;
         @(negedge clock);
      end
      rsp1_ready = 1'b1;
      #1;
      total++;
      if ({rsp1_valid, req0_ready} !== 2'b10) $display("FAIL rsp_no_accept: v1=%b rdy0=%b want 1 0", rsp1_valid, req0_ready);
      else passed++;
      @(negedge clock);
      total++;
      if ({busy, req0_ready} !== 2'b01) $display("FAIL next_accept: busy=%b rdy0=%b want 0 1", busy, req0_ready);
      else passed++;
      @(negedge clock);
      req0_valid = 1'b0;
      finish_job(1'b0, 32'd7);
   endtask

   task automatic test_reset_mid();
      int seen;
      start_job(1'b1, 32'd40, 32'd2);
      @(negedge clock);
      total++;
      if ({av_write, av_address} !== {1'b1, 3'd1}) $display("FAIL pre_reset_wr_b: wr=%b addr=%0d want 1 1", av_write, av_address);
      else passed++;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({av_write, busy, rsp_data} !== {1'b0, 1'b0, 32'd0})
         $display("FAIL async_reset: wr=%b busy=%b data=%0d want 0 0 0", av_write, busy, rsp_data);
      else passed++;
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clock);
         if (rsp0_valid || rsp1_valid || av_write || av_read || busy) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL abandoned_job: activity cycles=%0d want 0", seen);
      else passed++;
      start_job(1'b0, 32'd20, 32'd22);
      finish_job(1'b0, 32'd42);
   endtask

   initial begin
      total = 0; passed = 0;
      reset = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/add_job_arbiter.md
ADD_JOB_ARBITER -- requirements
Module: add_job_arbiter

Interface
- REQ-001: Parameter DATA_W, default 32: operand/result width, all data ports.
- REQ-002: Parameter ADDR_A, default 3'b000: adder slave address of operand A register.
- REQ-003: Parameter ADDR_B, default 3'b001: adder slave address of operand B register.
- REQ-004: Parameter ADDR_SUM, default 3'b011: adder slave address of sum readback.
- REQ-005: clock  input  1  single clock, all state on rising edge.
- REQ-006: reset  input  1  asynchronous, active-high reset.
- REQ-007: reqN_valid  input  1  requester N (N=0,1) presents an operand pair.
- REQ-008: reqN_a, reqN_b  input  DATA_W  requester N operands.
- REQ-009: reqN_ready  output  1  requester N's pair accepted this cycle.
- REQ-010: rspN_valid  output  1  result for requester N is available.
- REQ-011: rspN_ready  input  1  requester N takes the result.
- REQ-012: rsp_data  output  DATA_W  result, shared by both requesters.
- REQ-013: av_address  output  3  Avalon-MM master address to adder slave.
- REQ-014: av_write, av_read  output  1  Avalon-MM write/read strobes.
- REQ-015: av_writedata  output  DATA_W  write data.
- REQ-016: av_readdata  input  DATA_W  slave read data, valid the cycle after av_read (registered slave, no waitrequest).
- REQ-017: busy  output  1  high in every state except IDLE.

Function
- REQ-018: FSM states, one cycle each unless noted: IDLE, WR_A, WR_B, RD, CAP, RSP.
- REQ-019: IDLE: reqN_ready combinational, asserted only for the granted requester with reqN_valid high; on acceptance latch a/b and grant id, go WR_A.
- REQ-020: Arbitration: only one valid -> that one wins; both valid -> requester equal to priority pointer wins.
- REQ-021: Priority pointer: reset 0; on leaving RSP it is set to the other requester, so a requester never wins twice in a row under contention.
- REQ-022: WR_A: av_write=1, av_address=ADDR_A, av_writedata=latched a.
- REQ-023: WR_B: av_write=1, av_address=ADDR_B, av_writedata=latched b.
- REQ-024: RD: av_read=1, av_address=ADDR_SUM.
- REQ-025: CAP: rsp_data register loads av_readdata; go RSP.
- REQ-026: RSP: rspN_valid=1 for granted N only; hold rsp_data; stay until rspN_ready=1, then IDLE.
- REQ-027: av_write and av_read are never high in the same cycle; both are 0 in IDLE, CAP, RSP.
- REQ-028: av_address=0 and av_writedata=0 whenever no strobe is active.
- REQ-029: Latency: accept in cycle T -> rspN_valid first high in T+5 (one RSP cycle when rspN_ready is already high).
- REQ-030: Result is the slave's DATA_W-bit sum, no carry: wrap-around modulo 2^DATA_W.
- REQ-031: Requests arriving while busy are not accepted (ready=0) and are held by the requester; changes to reqN_a/b after acceptance have no effect on the job.
- REQ-032: Response and new acceptance never share a cycle; the earliest next acceptance is the cycle after the RSP handshake.

Reset
- REQ-033: reset high -> immediate IDLE, pointer=0, rsp_data=0, all outputs 0, without waiting for a clock edge.
- REQ-034: Reset mid-job abandons the job: no rsp_valid issued, no further slave access; after reset deasserts, normal operation resumes on the next edge.

Verification
- REQ-035: req0 a=5,b=7 alone, rsp0_ready=1 -> writes 5@0 and 7@1, read @3, rsp0_valid at T+5 with rsp_data=12.
- REQ-036: req0 and req1 valid same cycle after reset -> req0 served first; the next job goes to req1 even though req0 reasserts.
- REQ-037: a=32'hFFFFFFFF, b=2 -> rsp_data=1.
- REQ-038: rsp1_ready held low 4 cycles -> rsp1_valid and rsp_data stable for 4 cycles, FSM stays in RSP, req0_ready=0 throughout.
- REQ-039: reset pulse during WR_B -> av_write drops asynchronously, no rsp_valid, busy=0; a subsequent request completes correctly.
- REQ-040: Assertion, all tests: never av_write&av_read; never rsp0_valid&rsp1_valid; reqN_ready only in IDLE.
